// File: rtl/dot_product_engine_if.sv
// Load, start and result bundle for dot_product_engine.
// The bench/host drives through master; the engine sits on slave.
interface dot_product_engine_if #(
    parameter int Addr_Width     = 4,
    parameter int Para_Deg       = 2,
    parameter int Data_Width_In  = 8,
    parameter int Data_Width_Out = 16
);
    logic                              load_valid;
    logic [Addr_Width-1:0]             load_addr;
    logic [Para_Deg*Data_Width_In-1:0] load_a;
    logic [Para_Deg*Data_Width_In-1:0] load_b;
    logic                              start;
    logic [Addr_Width:0]               vec_len;
    logic                              signed_mode;
    logic                              acc_mode;
    logic [Data_Width_Out-1:0]         acc_init;
    logic                              busy;
    logic                              done;
    logic [Data_Width_Out-1:0]         result;
    logic                              overflow;

    modport master (
        output load_valid, load_addr, load_a, load_b,
        output start, vec_len, signed_mode, acc_mode, acc_init,
        input  busy, done, result, overflow
    );

    modport slave (
        input  load_valid, load_addr, load_a, load_b,
        input  start, vec_len, signed_mode, acc_mode, acc_init,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/dot_product_engine.sv
// Banked-SRAM dot-product engine: read, lane multiply, adder tree, accumulate.
// Operand words are loaded while idle; a start streams len words through the pipeline.
module dot_product_engine #(
    parameter int Addr_Width     = 4,
    parameter int Para_Deg       = 2,
    parameter int Data_Width_In  = 8,
    parameter int Data_Width_Out = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dot_product_engine_if.slave  bus
);
    localparam int RAM_DEPTH = 1 << Addr_Width;
    localparam int LW        = Para_Deg * Data_Width_In;
    localparam int PW        = 2 * Data_Width_In;
    localparam int SW        = Data_Width_Out + 1;
    localparam int TW        = Data_Width_Out + 2;
    localparam logic [Addr_Width:0] DEPTH_L = (Addr_Width + 1)'(RAM_DEPTH);
    localparam logic [Addr_Width:0] ONE_L   = (Addr_Width + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                     state_r;
    logic [LW-1:0]              mem_a_r [RAM_DEPTH];
    logic [LW-1:0]              mem_b_r [RAM_DEPTH];
    logic [Addr_Width:0]        len_r, addr_cnt_r, len_clamp_s;
    logic                       sm_r, accept_s;
    logic                       s1_v_r, s2_v_r, s3_v_r;
    logic [LW-1:0]              s1_a_r, s1_b_r;
    logic [Para_Deg*PW-1:0]     prod_s, s2_prod_r;
    logic [SW-1:0]              sum_s, s3_sum_r;
    logic [Data_Width_Out-1:0]  acc_r, seed_s;
    logic [TW-1:0]              total_s;
    logic                       ov_step_s, ov_run_r;

    // Lane product modulo 2^PW; sign bits only injected in signed mode.
    function automatic logic [PW-1:0] lane_mul(input logic [Data_Width_In-1:0] a,
                                               input logic [Data_Width_In-1:0] b,
                                               input logic                     sm);
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        logic signed [PW-1:0] p;
        ea = PW'($signed({sm & a[Data_Width_In-1], a}));
        eb = PW'($signed({sm & b[Data_Width_In-1], b}));
        p  = ea * eb;
        return $unsigned(p);
    endfunction

    function automatic logic [SW-1:0] widen(input logic [PW-1:0] p, input logic sm);
        return sm ? SW'($signed(p)) : SW'(p);
    endfunction

    assign accept_s    = (state_r == IDLE) && bus.start;
    assign seed_s      = bus.acc_mode ? bus.acc_init : {Data_Width_Out{1'b0}};
    assign len_clamp_s = (bus.vec_len > DEPTH_L) ? DEPTH_L : bus.vec_len;

    // Lane products, adder tree and overflow detection for the accumulate step.
    always_comb begin
        prod_s = '0;
        sum_s  = '0;
        for (int k = 0; k < Para_Deg; k++) begin
            prod_s[k*PW +: PW] = lane_mul(s1_a_r[k*Data_Width_In +: Data_Width_In],
                                          s1_b_r[k*Data_Width_In +: Data_Width_In], sm_r);
            sum_s = sum_s + widen(s2_prod_r[k*PW +: PW], sm_r);
        end
        // Signed: in range iff the top three bits agree; unsigned: nothing above W bits.
        if (sm_r) begin
            total_s   = TW'($signed(acc_r)) + TW'($signed(s3_sum_r));
            ov_step_s = (total_s[TW-1:TW-3] != 3'b000) && (total_s[TW-1:TW-3] != 3'b111);
        end else begin
            total_s   = {2'b00, acc_r} + {1'b0, s3_sum_r};
            ov_step_s = |total_s[TW-1:Data_Width_Out];
        end
    end

    // Operand SRAM banks: writable only while idle, never cleared by reset.
    always_ff @(posedge clk) begin
        if (bus.load_valid && (state_r == IDLE)) begin
            mem_a_r[bus.load_addr] <= bus.load_a;
            mem_b_r[bus.load_addr] <= bus.load_b;
        end
    end

    // Datapath pipeline: SRAM read, multiply, tree sum, accumulate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_r    <= 1'b0;
            s2_v_r    <= 1'b0;
            s3_v_r    <= 1'b0;
            s1_a_r    <= '0;
            s1_b_r    <= '0;
            s2_prod_r <= '0;
            s3_sum_r  <= '0;
            acc_r     <= '0;
            ov_run_r  <= 1'b0;
            sm_r      <= 1'b0;
        end else begin
            s1_v_r <= (state_r == RUN);
            if (state_r == RUN) begin
                s1_a_r <= mem_a_r[addr_cnt_r[Addr_Width-1:0]];
                s1_b_r <= mem_b_r[addr_cnt_r[Addr_Width-1:0]];
            end
            s2_v_r <= s1_v_r;
            if (s1_v_r) s2_prod_r <= prod_s;
            s3_v_r <= s2_v_r;
            if (s2_v_r) s3_sum_r <= sum_s;
            if (accept_s) begin
                acc_r    <= seed_s;
                ov_run_r <= 1'b0;
                sm_r     <= bus.signed_mode;
            end else if (s3_v_r) begin
                acc_r    <= total_s[Data_Width_Out-1:0];
                ov_run_r <= ov_run_r | ov_step_s;
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            len_r        <= '0;
            addr_cnt_r   <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        len_r        <= len_clamp_s;
                        addr_cnt_r   <= '0;
                        bus.overflow <= 1'b0;
                        if (len_clamp_s == '0) begin
                            state_r    <= FIN;
                            bus.done   <= 1'b1;
                            bus.result <= seed_s;
                        end else begin
                            state_r  <= RUN;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    addr_cnt_r <= addr_cnt_r + ONE_L;
                    if (addr_cnt_r == len_r - ONE_L) state_r <= DRAIN;
                end
                DRAIN: begin
                    if (!(s1_v_r || s2_v_r || s3_v_r)) begin
                        state_r      <= FIN;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.result   <= acc_r;
                        bus.overflow <= ov_run_r;
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_engine.sv
// Randomised bench for dot_product_engine: a cycle-level expectation of the
// handshake plus an arithmetic model of the dot product, compared every cycle.
module tb_dot_product_engine;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    bit   chk_en;

    logic [7:0]  ref_a [16][2];
    logic [7:0]  ref_b [16][2];
    logic        exp_busy, exp_done, exp_ovf;
    logic [15:0] exp_result;
    logic [15:0] r_m;
    bit          o_m;

    dot_product_engine_if #(.Addr_Width(4), .Para_Deg(2), .Data_Width_In(8), .Data_Width_Out(16)) bus ();

    dot_product_engine #(.Addr_Width(4), .Para_Deg(2), .Data_Width_In(8), .Data_Width_Out(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Every cycle, the outputs must match the expected handshake timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("done", 32'(bus.done), 32'(exp_done));
            chk("result", 32'(bus.result), 32'(exp_result));
            chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
        end
    end

    // Exact-integer dot product with wrap and per-step range checks.
    function automatic void model(input int len, input bit sm, input bit am, input logic [15:0] init,
                                  output logic [15:0] r, output bit ov);
        longint acc, s, t, va, vb;
        logic [15:0] w;
        ov  = 1'b0;
        acc = 0;
        if (am) acc = sm ? longint'($signed(init)) : longint'(init);
        for (int i = 0; i < len; i++) begin
            s = 0;
            for (int k = 0; k < 2; k++) begin
                va = sm ? longint'($signed(ref_a[i][k])) : longint'(ref_a[i][k]);
                vb = sm ? longint'($signed(ref_b[i][k])) : longint'(ref_b[i][k]);
                s += va * vb;
            end
            t = acc + s;
            if (sm) begin
                if (t < -32768 || t > 32767) ov = 1'b1;
            end else begin
                if (s > 65535 || t > 65535) ov = 1'b1;
            end
            w   = t[15:0];
            acc = sm ? longint'($signed(w)) : longint'(w);
        end
        w = acc[15:0];
        r = w;
    endfunction

    task automatic load_word(input int addr, input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] b0, input logic [7:0] b1);
        bus.load_valid = 1'b1;
        bus.load_addr  = 4'(addr);
        bus.load_a     = {a1, a0};
        bus.load_b     = {b1, b0};
        ref_a[addr][0] = a0; ref_a[addr][1] = a1;
        ref_b[addr][0] = b0; ref_b[addr][1] = b1;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
    endtask

    // One run: drives start, then walks the expected busy/done/result timeline edge by edge.
    task automatic run(input int vl, input bit sm, input bit am, input logic [15:0] init,
                       input bit same_load, input bit disturb,
                       output logic [15:0] r, output bit ov);
        int len;
        logic [7:0] x [4];
        len = (vl > 16) ? 16 : vl;
        bus.start       = 1'b1;
        bus.vec_len     = 5'(vl);
        bus.signed_mode = sm;
        bus.acc_mode    = am;
        bus.acc_init    = init;
        if (same_load) begin
            for (int j = 0; j < 4; j++) x[j] = 8'($urandom_range(0, 255));
            bus.load_valid = 1'b1;
            bus.load_addr  = 4'd0;
            bus.load_a     = {x[1], x[0]};
            bus.load_b     = {x[3], x[2]};
            ref_a[0][0] = x[0]; ref_a[0][1] = x[1];
            ref_b[0][0] = x[2]; ref_b[0][1] = x[3];
        end
        model(len, sm, am, init, r, ov);
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        exp_ovf        = 1'b0;
        if (len == 0) begin
            exp_done   = 1'b1;
            exp_result = r;
            @(posedge clk); #1;
            exp_done = 1'b0;
        end else begin
            exp_busy = 1'b1;
            for (int e = 1; e <= len + 3; e++) begin
                @(posedge clk); #1;
                if (disturb && e == 2) begin
                    bus.start      = 1'b1;
                    bus.vec_len    = 5'd1;
                    bus.load_valid = 1'b1;
                    bus.load_addr  = 4'($urandom_range(0, 15));
                    bus.load_a     = 16'($urandom_range(0, 65535));
                    bus.load_b     = 16'($urandom_range(0, 65535));
                end
                if (disturb && e == 3) begin
                    bus.start      = 1'b0;
                    bus.load_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            exp_busy   = 1'b0;
            exp_done   = 1'b1;
            exp_result = r;
            exp_ovf    = ov;
            @(posedge clk); #1;
            exp_done = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.load_valid = 1'b0; bus.load_addr = 4'd0; bus.load_a = 16'd0; bus.load_b = 16'd0;
        bus.start = 1'b0; bus.vec_len = 5'd0; bus.signed_mode = 1'b0;
        bus.acc_mode = 1'b0; bus.acc_init = 16'd0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0; exp_result = 16'd0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
        reset_n = 1'b1;

        // Background words so a clamped 16-word run reads defined data.
        for (int i = 4; i < 16; i++)
            load_word(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) load_word(i, 8'(i + 1), 8'(i + 1), 8'd2, 8'd2);

        run(4, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, r_m, o_m);
        chk("s1_model", 32'(r_m), 32'd40);
        chk("s1_result", 32'(bus.result), 32'd40);
        run(4, 1'b0, 1'b1, 16'd100, 1'b0, 1'b0, r_m, o_m);
        chk("s2_result", 32'(bus.result), 32'd140);

        for (int i = 0; i < 2; i++) load_word(i, 8'hFF, 8'hFF, 8'd3, 8'd3);
        run(2, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, r_m, o_m);
        chk("s3_signed", 32'(bus.result), 32'h0000FFF4);
        chk("s3_signed_ovf", 32'(bus.overflow), 32'd0);
        run(2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, r_m, o_m);
        chk("s3_unsigned", 32'(bus.result), 32'd3060);

        load_word(0, 8'd255, 8'd255, 8'd255, 8'd255);
        run(1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, r_m, o_m);
        chk("s4_result", 32'(bus.result), 32'd64514);
        chk("s4_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 4; i++) load_word(i, 8'(i + 1), 8'(i + 1), 8'd2, 8'd2);
        run(4, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, r_m, o_m);
        chk("s4_ovf_cleared", 32'(bus.overflow), 32'd0);

        run(0, 1'b0, 1'b1, 16'd7, 1'b0, 1'b0, r_m, o_m);
        chk("s5_len0", 32'(bus.result), 32'd7);
        run(20, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, r_m, o_m);

        // Start and load pulsed mid-run must be ignored.
        run(4, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, r_m, o_m);
        chk("s6_disturb", 32'(bus.result), 32'd40);

        // Same-edge load and start: the new word 0 is part of this run.
        run(3, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, r_m, o_m);

        for (int it = 0; it < 16; it++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                load_word(int'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            run(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_m, o_m);
        end

        // Reset in the middle of RUN aborts the run without a done pulse.
        bus.start = 1'b1; bus.vec_len = 5'd6; bus.signed_mode = 1'b0; bus.acc_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_busy  = 1'b1;
        exp_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_result = 16'd0; exp_ovf = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_ovf", 32'(bus.overflow), 32'd0);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk); #1;

        // SRAM content survives reset.
        run(4, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, r_m, o_m);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Parametrised successor to the single-lane dot-product datapath.
- Holds two operand vectors in internal banked SRAM, each word carrying Para_Deg lanes.
- On a start handshake, streams vec_len words through a fixed 4-stage pipeline: SRAM read, lane multiply, lane adder tree, accumulate.
- Adds runtime vector length, a signed/unsigned mode, an optional accumulate-onto-previous-output mode, a sticky overflow flag and a start/busy/done handshake.

Parameters:
- Addr_Width, 4, SRAM word-address width; Ram_Depth = 1<<Addr_Width words per bank.
- Para_Deg, 2, lanes per word (parallel multipliers).
- Data_Width_In, 8, operand element width.
- Data_Width_Out, 16, accumulator/result width.

Ports:
- clk  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  write load_a/load_b into word load_addr this edge (IDLE only).
- load_addr  in  Addr_Width  word address for load.
- load_a  in  Para_Deg*Data_Width_In  vector A word, lane k at [k*Data_Width_In +: Data_Width_In].
- load_b  in  Para_Deg*Data_Width_In  vector B word, same lane packing.
- start  in  1  begin computation (sampled in IDLE only).
- vec_len  in  Addr_Width+1  number of words to process, sampled with start.
- signed_mode  in  1  1 = two's-complement operands, sampled with start.
- acc_mode  in  1  1 = accumulator seeded with acc_init, else 0; sampled with start.
- acc_init  in  Data_Width_Out  previous output to accumulate onto.
- busy  out  1  high from the edge after start is accepted until done.
- done  out  1  one-cycle pulse when result is final.
- result  out  Data_Width_Out  final dot product; holds until the next accepted start.
- overflow  out  1  sticky for the current run; holds with result.

Behaviour:
- Reset (async, reset_n=0): busy=0, done=0, result=0, overflow=0, FSM=IDLE, all pipeline valid bits cleared. SRAM contents are not cleared.
- FSM states:
  - IDLE: load writes allowed. start=1 latches modes and len = min(vec_len, Ram_Depth), seeds acc, clears overflow. Goes to RUN, or to FIN if len==0.
  - RUN: issues read addresses 0..len-1, one per cycle, then goes to DRAIN.
  - DRAIN: waits for the pipeline valid bits to empty (3 cycles), then goes to FIN.
  - FIN: done=1, result=acc, back to IDLE.
- Latency: done is asserted in the cycle after exactly len+4 rising edges following the start-sampling edge. For len==0 it is after 1 edge, with result = acc_mode ? acc_init : 0.
- Pipeline:
  - S1: registered SRAM read.
  - S2: per-lane product, 2*Data_Width_In bits, sign-extended per signed_mode.
  - S3: sum of Para_Deg products, extended to Data_Width_Out+1 bits.
  - S4: acc <= acc + S3 sum, truncated mod 2^Data_Width_Out.
- Overflow (sticky):
  - Unsigned: set on carry out of bit Data_Width_Out-1, or when any lane sum exceeds the Data_Width_Out range.
  - Signed: set when the true sum falls outside [-2^(W-1), 2^(W-1)-1].
- load_valid while busy: ignored, memory unchanged.
- start while busy or in FIN: ignored.
- start and load_valid on the same IDLE edge: the write commits first and is visible to the run, because the first read occurs on the following edge.
- vec_len > Ram_Depth: clamped to Ram_Depth.
- Asynchronous reset mid-run: the run is aborted with no done pulse; restart requires a new start.

Test Plan:
- Setup for all scenarios: Para_Deg=2, Data_Width_In=8, Data_Width_Out=16.
- 1) Load word i (i=0..3) with a lanes=i+1, b lanes=2; start vec_len=4, unsigned, acc_mode=0 -> done 8 edges after start, result=40, overflow=0, busy high 8 cycles.
- 2) Same data, acc_mode=1, acc_init=100 -> result=140.
- 3) Words 0..1 with a=8'hFF, b=3; signed_mode=1, vec_len=2 -> result=16'hFFF4 (-12), overflow=0. Same data unsigned -> result=3060.
- 4) Word 0 with a=b=255, unsigned, vec_len=1 -> result=64514, overflow=1. Next run (scenario 1 data) -> overflow=0.
- 5) vec_len=0, acc_mode=1, acc_init=7 -> done 1 edge later, result=7. vec_len=20 -> treated as 16, done after 20 edges.
- 6) Pulse start and load_valid while busy -> ignored, result matches the original run. Drive reset_n=0 mid-RUN -> busy/done/result/overflow=0 immediately, no done pulse afterwards.
